// File: rtl/rs232out_fifo.sv
// Transmit byte FIFO between the rs232 register interface and the rs232out shifter.
// Buffers CPU bursts and loads one byte into rs232out whenever it is idle.
module rs232out_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_w,
    input  logic [7:0]            in_d,
    output logic                  in_busy,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  out_busy,
    output logic                  out_we,
    output logic [7:0]            out_d
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]            state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Full/empty come from the registered count, so a push while full is
    // rejected even if a pop frees a slot in the same cycle.
    always_comb begin
        full    = (count == FULL_COUNT);
        empty   = (count == '0);
        push    = in_w & ~full;
        pop     = (state == IDLE) & ~empty & ~out_busy;
        in_busy = full;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (in_w & full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // HOLD skips one cycle because rs232out raises busy a cycle after the load.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            out_we <= 1'b0;
            out_d  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_we <= 1'b1;
                        out_d  <= mem[rd_ptr];
                        state  <= HOLD;
                    end else begin
                        out_we <= 1'b0;
                    end
                end
                HOLD: begin
                    out_we <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    out_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232out_fifo.sv
// Randomised scoreboard bench for rs232out_fifo against a queue-based reference model.
module tb_rs232out_fifo;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_w = 1'b0;
    logic [7:0] in_d = '0;
    logic       in_busy;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic [4:0] count;
    logic       out_busy;
    logic       out_we;
    logic [7:0] out_d;

    logic busy_force = 1'b0;
    logic auto_mode  = 1'b0;
    logic auto_busy  = 1'b0;

    assign out_busy = auto_mode ? auto_busy : busy_force;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int ncyc  = 0;
    int we_times[$];

    // Reference model: stored bytes and bytes expected on the output.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_we  = 1'b0;
    logic       mon_en = 1'b0;
    logic       prev_we = 1'b0;
    logic       mon_we = 1'b0;

    rs232out_fifo #(.DEPTH_LOG2(4)) dut (
        .clock(clock), .rst_n(rst_n), .in_w(in_w), .in_d(in_d),
        .in_busy(in_busy), .overflow(overflow), .overflow_clr(overflow_clr),
        .count(count), .out_busy(out_busy), .out_we(out_we), .out_d(out_d)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // A load is allowed only if the previous cycle did not load.
    always @(posedge clock or negedge rst_n) begin
        logic full_now;
        logic pop_now;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_we  = 1'b0;
        end else begin
            full_now = (mq.size() == DEPTH);
            pop_now  = !m_we && (mq.size() != 0) && !out_busy;
            if (in_w && full_now) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (pop_now) sb.push_back(mq.pop_front());
            if (in_w && !full_now) mq.push_back(in_d);
            m_we = pop_now;
        end
    end

    always @(negedge clock) begin
        ncyc++;
        if (mon_en) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("in_busy", 32'(in_busy), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("out_we", 32'(out_we), 32'(m_we));
            chk("back_to_back", 32'(out_we & prev_we), 32'd0);
            if (out_we === 1'b1) begin
                n_out++;
                we_times.push_back(ncyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_d_unexpected: got %0h expected no byte", out_d);
                end else begin
                    chk("out_d", 32'(out_d), 32'(sb.pop_front()));
                end
            end
        end
        prev_we = out_we;
        mon_we  = out_we;
    end

    // Model of rs232out: busy for 3 cycles starting one cycle after a load.
    always @(posedge clock) begin
        int bcnt;
        #1;
        if (!auto_mode) begin
            bcnt = 0;
            auto_busy = 1'b0;
        end else begin
            if (mon_we) bcnt = 3;
            else if (bcnt != 0) bcnt--;
            auto_busy = (bcnt != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_w = 1'b1;
        in_d = b;
        cyc();
        in_w = 1'b0;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clock);
        mon_en = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_d", 32'(out_d), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_busy", 32'(in_busy), 32'd0);
        @(negedge clock);
        #2 rst_n = 1'b1;
        cyc();

        // Single byte latency
        push(8'h41);
        chk("t1_count_t1", 32'(count), 32'd1);
        chk("t1_we_t1", 32'(out_we), 32'd0);
        cyc();
        chk("t1_we_t2", 32'(out_we), 32'd1);
        chk("t1_d_t2", 32'(out_d), 32'h41);
        cyc();
        chk("t1_we_t3", 32'(out_we), 32'd0);
        chk("t1_count_t3", 32'(count), 32'd0);

        // Fill to full, overflow, then drain in order
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_count_full", 32'(count), 32'd16);
        chk("t2_in_busy", 32'(in_busy), 32'd1);
        chk("t2_ovf_before", 32'(overflow), 32'd0);
        push(8'hFF);
        chk("t2_ovf_after", 32'(overflow), 32'd1);
        chk("t2_count_kept", 32'(count), 32'd16);
        busy_force = 1'b0;
        repeat (40) cyc();
        chk("t2_drained", 32'(count), 32'd0);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // Wrap-around bursts against a modelled rs232out
        auto_mode = 1'b1;
        base = n_out;
        repeat (4) begin
            for (int i = 0; i < 10; i++) push(8'($urandom));
            repeat (70) cyc();
        end
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        chk("t3_bytes_out", 32'(n_out - base), 32'd40);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        auto_mode = 1'b0;

        // Full with simultaneous push and pop
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push(8'($urandom));
        chk("t4_full", 32'(count), 32'd16);
        busy_force = 1'b0;
        in_w = 1'b1;
        in_d = 8'hAA;
        cyc();
        in_w = 1'b0;
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_count", 32'(count), 32'd15);
        chk("t4_we", 32'(out_we), 32'd1);
        busy_force = 1'b1;
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        busy_force = 1'b0;
        repeat (40) cyc();
        chk("t4_drained", 32'(count), 32'd0);

        // Reset while a load is in flight
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        busy_force = 1'b0;
        cyc();
        chk("t5_pre_count", 32'(count), 32'd5);
        chk("t5_pre_we", 32'(out_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_we_async", 32'(out_we), 32'd0);
        chk("t5_count_async", 32'(count), 32'd0);
        chk("t5_ovf_async", 32'(overflow), 32'd0);
        @(negedge clock);
        #2 rst_n = 1'b1;
        cyc();
        base = n_out;
        repeat (20) cyc();
        chk("t5_no_stale", 32'(n_out - base), 32'd0);

        // Continuous drain cadence
        base = we_times.size();
        for (int i = 0; i < 4; i++) push(8'($urandom));
        repeat (12) cyc();
        chk("t6_pulses", 32'(we_times.size() - base), 32'd4);
        for (int i = base + 1; i < we_times.size(); i++)
            chk("t6_spacing", 32'(we_times[i] - we_times[i-1]), 32'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_w = ($urandom_range(0, 99) < 60);
            in_d = 8'($urandom);
            busy_force = ($urandom_range(0, 99) < 30);
            overflow_clr = ($urandom_range(0, 99) < 10);
            cyc();
        end
        in_w = 1'b0;
        overflow_clr = 1'b0;
        busy_force = 1'b0;
        repeat (40) cyc();
        chk("rand_drained", 32'(count), 32'd0);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
